// File: rtl/rbz_vec_pkg.sv
// Shared constants, reset vectors and FSM states for the vector SPI loader.
package rbz_vec_pkg;
  localparam int FIELD_W    = 15;
  localparam int NUM_FIELDS = 6;
  localparam int PKT_BITS   = FIELD_W * NUM_FIELDS;

  // Q6.9 reset pose: player at (8.5, 8.5) facing -y, half-width view plane
  localparam logic [FIELD_W-1:0] RST_PX = 15'h1100;
  localparam logic [FIELD_W-1:0] RST_PY = 15'h1100;
  localparam logic [FIELD_W-1:0] RST_FX = 15'h0000;
  localparam logic [FIELD_W-1:0] RST_FY = 15'h7E00;
  localparam logic [FIELD_W-1:0] RST_VX = 15'h0100;
  localparam logic [FIELD_W-1:0] RST_VY = 15'h0000;

  typedef enum logic [1:0] {RESYNC, IDLE, RECV} state_t;
endpackage

// File: rtl/rbz_sync_edge.sv
// 2-FF synchronizer for one asynchronous pin, with registered rise/fall pulses.
// q_o is the level aligned with the pulses.
module rbz_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic       prev_q, rise_q, fall_q;

  // Reset low so a select already asserted at reset release never looks idle
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
      fall_q <= ~sync_q[1] & prev_q;
    end
  end

  assign q_o    = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/rbz_vec_spi_loader.sv
// Receives six Q6.9 vector fields over SPI and presents them registered to the raycaster.
// RBZ_VEC_FRAME_SYNC_EN: stage packets and commit them only on i_frame_tick.
module rbz_vec_spi_loader
  import rbz_vec_pkg::*;
#(
  parameter int FIELD_W    = rbz_vec_pkg::FIELD_W,
  parameter int NUM_FIELDS = rbz_vec_pkg::NUM_FIELDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_sclk,
  input  logic               i_mosi,
  input  logic               i_ss_n,
  input  logic               i_frame_tick,
  output logic [FIELD_W-1:0] o_px,
  output logic [FIELD_W-1:0] o_py,
  output logic [FIELD_W-1:0] o_fx,
  output logic [FIELD_W-1:0] o_fy,
  output logic [FIELD_W-1:0] o_vx,
  output logic [FIELD_W-1:0] o_vy,
  output logic               o_pending,
  output logic [3:0]         o_err_cnt
);
  localparam int PKT_BITS = FIELD_W * NUM_FIELDS;
  localparam logic [PKT_BITS-1:0] RST_OUT =
    PKT_BITS'({RST_PX, RST_PY, RST_FX, RST_FY, RST_VX, RST_VY});

  logic sclk_rise, mosi_lvl, ss_lvl, ss_rise, ss_fall;
  logic unused_sclk_lvl, unused_sclk_fall, unused_mosi_rise, unused_mosi_fall;

  rbz_sync_edge u_sclk (.clk(clk), .reset(reset), .d_i(i_sclk), .q_o(unused_sclk_lvl),
                        .rise_o(sclk_rise), .fall_o(unused_sclk_fall));
  rbz_sync_edge u_mosi (.clk(clk), .reset(reset), .d_i(i_mosi), .q_o(mosi_lvl),
                        .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall));
  rbz_sync_edge u_ss   (.clk(clk), .reset(reset), .d_i(i_ss_n), .q_o(ss_lvl),
                        .rise_o(ss_rise), .fall_o(ss_fall));

  state_t              state_q, state_d;
  logic [PKT_BITS-1:0] sr_q, sr_d, out_q, out_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [3:0]          err_q, err_d;
  logic                pkt_ok;
`ifdef RBZ_VEC_FRAME_SYNC_EN
  logic [PKT_BITS-1:0] stage_q, stage_d;
  logic                pend_q, pend_d;
`else
  logic                unused_tick;
  assign unused_tick = i_frame_tick;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESYNC;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      out_q   <= RST_OUT;
`ifdef RBZ_VEC_FRAME_SYNC_EN
      stage_q <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= out_d;
`ifdef RBZ_VEC_FRAME_SYNC_EN
      stage_q <= stage_d;
      pend_q  <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    out_d   = out_q;
    pkt_ok  = 1'b0;
`ifdef RBZ_VEC_FRAME_SYNC_EN
    stage_d = stage_q;
    pend_d  = pend_q;
    // Commit uses the pre-edge pending flag, so a packet landing this cycle waits a frame
    if (i_frame_tick && pend_q) begin
      out_d  = stage_q;
      pend_d = 1'b0;
    end
`endif
    case (state_q)
      RESYNC: if (ss_lvl) state_d = IDLE;
      IDLE: if (ss_fall) begin
        state_d = RECV;
        cnt_d   = '0;
      end
      RECV: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == 7'(PKT_BITS)) pkt_ok = 1'b1;
          else if (err_q != 4'hF)    err_d  = err_q + 4'd1;
        end else if (sclk_rise) begin
          sr_d = {sr_q[PKT_BITS-2:0], mosi_lvl};
          if (cnt_q != 7'h7F) cnt_d = cnt_q + 7'd1;
        end
      end
      default: state_d = RESYNC;
    endcase
    if (pkt_ok) begin
`ifdef RBZ_VEC_FRAME_SYNC_EN
      stage_d = sr_q;
      pend_d  = 1'b1;
`else
      out_d   = sr_q;
`endif
    end
  end

  assign o_px      = out_q[6*FIELD_W-1 -: FIELD_W];
  assign o_py      = out_q[5*FIELD_W-1 -: FIELD_W];
  assign o_fx      = out_q[4*FIELD_W-1 -: FIELD_W];
  assign o_fy      = out_q[3*FIELD_W-1 -: FIELD_W];
  assign o_vx      = out_q[2*FIELD_W-1 -: FIELD_W];
  assign o_vy      = out_q[FIELD_W-1   -: FIELD_W];
  assign o_err_cnt = err_q;
`ifdef RBZ_VEC_FRAME_SYNC_EN
  assign o_pending = pend_q;
`else
  assign o_pending = 1'b0;
`endif
endmodule

// File: tb/tb_rbz_vec_spi_loader.sv
// Self-checking bench: packet-level model of the loader compared every cycle, plus literal pins.
module tb_rbz_vec_spi_loader;
`ifdef RBZ_VEC_FRAME_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam logic [89:0] RST_VEC =
    {15'h1100, 15'h1100, 15'h0000, 15'h7E00, 15'h0100, 15'h0000};

  logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1, tick = 1'b0;
  logic [14:0] o_px, o_py, o_fx, o_fy, o_vx, o_vy;
  logic        o_pending;
  logic [3:0]  o_err_cnt;

  rbz_vec_spi_loader dut (
    .clk(clk), .reset(reset), .i_sclk(sclk), .i_mosi(mosi), .i_ss_n(ss_n),
    .i_frame_tick(tick), .o_px(o_px), .o_py(o_py), .o_fx(o_fx), .o_fy(o_fy),
    .o_vx(o_vx), .o_vy(o_vy), .o_pending(o_pending), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  // Packet-level reference state
  logic [89:0] m_out, m_stage;
  bit          m_pend;
  int          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_out = RST_VEC; m_stage = '0; m_pend = 1'b0; m_err = 0;
  endfunction

  function automatic void m_tick();
    if (SYNC && m_pend) begin
      m_out  = m_stage;
      m_pend = 1'b0;
    end
  endfunction

  function automatic void m_pkt_end(input int n, input logic [127:0] d);
    if (n == 90) begin
      if (SYNC) begin m_stage = d[89:0]; m_pend = 1'b1; end
      else m_out = d[89:0];
    end else if (m_err < 15) m_err++;
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("px",  o_px, m_out[89:75]);
      chk("py",  o_py, m_out[74:60]);
      chk("fx",  o_fx, m_out[59:45]);
      chk("fy",  o_fy, m_out[44:30]);
      chk("vx",  o_vx, m_out[29:15]);
      chk("vy",  o_vy, m_out[14:0]);
      chk("pending", o_pending, m_pend);
      chk("err_cnt", o_err_cnt, m_err[3:0]);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bits(input int n, input logic [127:0] d);
    for (int i = 0; i < n; i++) begin
      mosi = d[n-1-i];
      wait_n(4); sclk = 1'b1;
      wait_n(4); sclk = 1'b0;
    end
  endtask

  // Select release is seen internally 3 cycles later; the model moves at that point
  task automatic send_pkt(input int n, input logic [127:0] d, input bit with_tick);
    ss_n = 1'b0; wait_n(4);
    clock_bits(n, d);
    wait_n(4); ss_n = 1'b1;
    wait_n(3);
    if (with_tick) begin tick = 1'b1; m_tick(); end
    m_pkt_end(n, d);
    wait_n(1); tick = 1'b0;
    wait_n(4);
  endtask

  task automatic frame_tick();
    tick = 1'b1; m_tick();
    wait_n(1); tick = 1'b0;
    wait_n(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] pa, pb, pc, pd;
    pa = {38'd0, 15'h0A00, 15'h0C00, 15'h0200, 15'h0000, 15'h0000, 15'h0100};
    pb = {38'd0, 15'h1234, 15'h0567, 15'h7001, 15'h0042, 15'h3FFF, 15'h2222};
    pc = {38'd0, 15'h0F0F, 15'h70F0, 15'h0001, 15'h4000, 15'h1111, 15'h0ABC};
    pd = {38'd0, 15'h0333, 15'h0444, 15'h0555, 15'h0666, 15'h0777, 15'h0888};

    @(negedge clk);
    m_reset(); chk_en = 1'b1;
    wait_n(2); reset = 1'b0;
    wait_n(4);
    chk("rst_px", o_px, 15'h1100); chk("rst_py", o_py, 15'h1100);
    chk("rst_fx", o_fx, 15'h0000); chk("rst_fy", o_fy, 15'h7E00);
    chk("rst_vx", o_vx, 15'h0100); chk("rst_vy", o_vy, 15'h0000);
    chk("rst_pend", o_pending, 0); chk("rst_err", o_err_cnt, 0);

    send_pkt(90, pa, 1'b0);
    wait_n(5);
    frame_tick();
    chk("valid_px", o_px, 15'h0A00); chk("valid_py", o_py, 15'h0C00);
    chk("valid_fx", o_fx, 15'h0200); chk("valid_vy", o_vy, 15'h0100);
    chk("valid_pend", o_pending, 0);

    send_pkt(89, pb, 1'b0);
    send_pkt(91, pb, 1'b0);
    frame_tick();
    chk("short_long_err", o_err_cnt, 2);
    chk("short_long_px", o_px, 15'h0A00);

    send_pkt(90, pb, 1'b0);
    send_pkt(90, pc, 1'b0);
    frame_tick();
    chk("latest_wins_px", o_px, 15'h0F0F);
    chk("latest_wins_vy", o_vy, 15'h0ABC);

    send_pkt(90, pd, 1'b1);
    wait_n(4);
    frame_tick();
    chk("coincident_px", o_px, 15'h0333);
    chk("coincident_pend", o_pending, 0);

    // Clock activity with select idle must be ignored
    for (int i = 0; i < 6; i++) begin
      mosi = i[0]; wait_n(4); sclk = 1'b1; wait_n(4); sclk = 1'b0;
    end
    wait_n(4);

    for (int i = 0; i < 16; i++) send_pkt($urandom_range(0, 8), {4{$urandom}}, 1'b0);
    chk("err_saturate", o_err_cnt, 15);

    // Reset in the middle of a packet: the tail must not count as a packet
    ss_n = 1'b0; wait_n(4);
    clock_bits(40, pb);
    reset = 1'b1; m_reset();
    wait_n(2); reset = 1'b0;
    clock_bits(50, pb);
    wait_n(4); ss_n = 1'b1;
    wait_n(10);
    chk("midrst_err", o_err_cnt, 0);
    send_pkt(90, pa, 1'b0);
    frame_tick();
    chk("midrst_next_px", o_px, 15'h0A00);
    chk("midrst_next_err", o_err_cnt, 0);

    for (int i = 0; i < 20; i++) begin
      int n;
      case ($urandom_range(0, 5))
        0: n = 88;
        1: n = 89;
        2: n = 91;
        default: n = 90;
      endcase
      send_pkt(n, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) frame_tick();
    end
    frame_tick();
    wait_n(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rbz_vec_spi_loader.md
# rbz_vec_spi_loader

Receives player/view vectors over the dedicated vector SPI pins and presents them, registered and frame-coherent, to the raycaster core. Sits directly upstream of the raycaster/tracer: the core consumes its six vector outputs. Incoming packets are staged and committed only at a frame boundary, so one frame never renders with mixed old and new vectors.

## Interface
- Parameters:
- `FIELD_W`, 15: width of each vector field, signed Q6.9.
- `NUM_FIELDS`, 6: fields per packet; packet length `PKT_BITS = FIELD_W*NUM_FIELDS` = 90.
- Ports:
- `clk`  in  1  system clock (pixel clock).
- `reset`  in  1  synchronous, active-high reset.
- `i_sclk`  in  1  SPI clock from pin, asynchronous; mode 0, sample on rising edge.
- `i_mosi`  in  1  SPI data from pin, asynchronous; MSB first.
- `i_ss_n`  in  1  SPI select from pin, asynchronous, active-low.
- `i_frame_tick`  in  1  one-cycle pulse at frame start (vpos wrap).
- `o_px`, `o_py`  out  FIELD_W  player position.
- `o_fx`, `o_fy`  out  FIELD_W  facing vector.
- `o_vx`, `o_vy`  out  FIELD_W  view-plane vector.
- `o_pending`  out  1  valid packet staged, awaiting commit.
- `o_err_cnt`  out  4  saturating count of rejected packets.

## Operation
- All three SPI pins pass through a 2-FF synchronizer plus an edge-detect register; all logic uses the synchronized copies.
- Packet order: px, py, fx, fy, vx, vy; each field MSB first; 90 bits total.
- FSM states:
- RESYNC: entered on reset; waits for synchronized ss_n high, then goes to IDLE. A transfer already in progress at reset release is ignored.
- IDLE: ss_n falling edge → RECV; bit count cleared.
- RECV: each sclk rising edge shifts mosi into a 90-bit shift register; 7-bit bit counter saturates at 127. On the ss_n rising edge: count == 90 → copy shift register into the staging register and set `o_pending`; otherwise discard and increment `o_err_cnt` (saturates at 15). Either way → IDLE.
- Commit: when `i_frame_tick` is high and `o_pending` is 1, the staging register loads the output registers and clears `o_pending`.
- A new valid packet while `o_pending` is 1 overwrites the staging register (latest wins). No error is counted.
- ss_n rise and `i_frame_tick` in the same cycle: the packet is staged this cycle and commits at the next tick, never the current one.
- sclk edges while ss_n is high are ignored.
- Reset values:
- `o_px` = `o_py` = 15'h1100 (8.5).
- `o_fx` = 15'h0000.
- `o_fy` = 15'h7E00 (−1.0).
- `o_vx` = 15'h0100 (0.5).
- `o_vy` = 15'h0000.
- `o_pending` = 0; `o_err_cnt` = 0; FSM in RESYNC.

## Timing
- Pin-to-action latency: 3 clk cycles (2 synchronizer stages + edge detect).
- SPI constraint: sclk high and low each ≥ 3 clk periods. ss_n setup/hold to the first/last sclk edge ≥ 3 clk periods.
- Staging: `o_pending` rises 1 cycle after the internal ss_n rising-edge detect.
- Commit: outputs and `o_pending` update on the clk edge that samples `i_frame_tick` high; new values are visible the cycle after the tick.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- `RBZ_VEC_FRAME_SYNC_EN` defined: frame-synchronous commit, as described above.
- Not defined: a valid packet loads the outputs directly, 1 cycle after the ss_n rising-edge detect. `i_frame_tick` is ignored; `o_pending` is tied 0; the staging register is not built. Error counting is unchanged.

## Structure
- Package `rbz_vec_pkg`:
- `FIELD_W`, `NUM_FIELDS`, `PKT_BITS`.
- The six reset constants.
- FSM state enum: RESYNC, IDLE, RECV.
- Sub-module `rbz_sync_edge`: 2-FF synchronizer with registered rise/fall pulse outputs. Instantiated three times, one per SPI pin.

## Test plan
- Reset: assert `reset` 2 cycles → outputs equal 1100/1100/0000/7E00/0100/0000; `o_pending` = 0; `o_err_cnt` = 0.
- Valid packet: send px=0x0A00, py=0x0C00, fx=0x0200, fy=0, vx=0, vy=0x0100 → `o_pending` = 1 and outputs unchanged until `i_frame_tick`. Cycle after the tick: outputs equal the sent values and `o_pending` = 0.
- Short packet (89 bits) then long packet (91 bits) → outputs unchanged, `o_pending` = 0, `o_err_cnt` = 2. With 16 bad packets, `o_err_cnt` holds at 15.
- Two valid packets A then B before any tick → a single tick commits B only.
- ss_n rise coincident with `i_frame_tick` → no commit on that tick; commit on the following tick.
- `reset` pulsed mid-packet with ss_n held low → remainder of that packet ignored, `o_err_cnt` stays 0. The next complete packet is accepted.
